// File: rtl/key_debounce_irq_ctrl.sv
// -----------------------------------------------------------------------------
// key_debounce_irq_ctrl
//
// Avalon-MM slave for the board push-keys (active-low, 0 = pressed). Each key
// is synchronised through two flops, then debounced by its own small FSM and
// counter: a new level is accepted only after it has held for DEBOUNCE_CYCLES
// consecutive clocks. Accepted presses are latched in an edge-capture register
// and raise a maskable, registered interrupt.
//
// Build option:
//   KEY_RELEASE_IRQ_EN - when defined, releases (0->1 of the debounced level)
//                        are captured as events too; otherwise only presses.
//
// Register map (word addresses, unused upper bits read 0):
//   0 DATA    RO  debounced key levels
//   1 IRQMASK RW  interrupt mask
//   2 EDGECAP R/W1C captured events (a same-cycle event beats the clear)
//   3 RAW     RO  synchronised, un-debounced levels
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   address    in   [1:0] register select
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   [31:0] write data
//   readdata   out  [31:0] registered read data (1 clock latency)
//   in_port    in   [WIDTH-1:0] raw asynchronous key pins, active-low
//   irq        out  active-high interrupt request
// -----------------------------------------------------------------------------
module key_debounce_irq_ctrl #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [0:0] ST_STABLE   = 1'b0;
  localparam logic [0:0] ST_CHANGING = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_deb;
  logic [WIDTH-1:0] r_state;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_ecap;
  logic [31:0]      r_readdata;
  logic             r_irq;

  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_evt;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  assign readdata = r_readdata;
  assign irq      = r_irq;

  // Only the low WIDTH bits of writedata are meaningful.
  assign w_unused_wdata = ^writedata;

  // Two-flop synchroniser; resets to "released".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

  // A key's new level is accepted on the last counted cycle of a run of
  // disagreement between the synchronised and debounced levels.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = (r_state[i] == ST_CHANGING) &&
                    (r_sync2[i] != r_deb[i]) &&
                    (r_cnt[i] == CNT_LAST);
    end
  end

  // Acceptance implies the level flips, so the new level alone tells
  // press (new level 0) from release (new level 1).
`ifdef KEY_RELEASE_IRQ_EN
  assign w_evt = w_accept;
`else
  assign w_evt = w_accept & ~r_sync2;
`endif

  // Per-key debounce FSMs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= '0;
      r_deb   <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case (r_state[i])
          ST_STABLE: begin
            if (r_sync2[i] != r_deb[i]) begin
              r_state[i] <= ST_CHANGING;
              r_cnt[i]   <= CNT_W'(1);
            end
          end
          default: begin
            if (r_sync2[i] == r_deb[i]) begin
              // Bounced back before the hold time: drop it silently.
              r_state[i] <= ST_STABLE;
              r_cnt[i]   <= '0;
            end else if (w_accept[i]) begin
              r_deb[i]   <= r_sync2[i];
              r_state[i] <= ST_STABLE;
              r_cnt[i]   <= '0;
            end else begin
              r_cnt[i]   <= r_cnt[i] + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign w_wr  = chipselect && !write_n;
  assign w_clr = (w_wr && (address == 2'd2)) ? writedata[WIDTH-1:0] : '0;

  // Mask, edge capture and interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_ecap <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr && (address == 2'd1)) begin
        r_mask <= writedata[WIDTH-1:0];
      end
      // OR-ing events in after the clear lets a coincident event survive.
      r_ecap <= (r_ecap & ~w_clr) | w_evt;
      r_irq  <= |(r_ecap & r_mask);
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0:    w_rd_mux[WIDTH-1:0] = r_deb;
      2'd1:    w_rd_mux[WIDTH-1:0] = r_mask;
      2'd2:    w_rd_mux[WIDTH-1:0] = r_ecap;
      default: w_rd_mux[WIDTH-1:0] = r_sync2;
    endcase
  end

  // Read data is refreshed every clock, regardless of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rd_mux;
    end
  end

endmodule
